// File: rtl/cpu_pkg.sv
// Shared opcode, ALU-op, IR-field and state definitions for the hardwired control sequencer.
package cpu_pkg;

  localparam int unsigned IR_W      = 32;
  localparam int unsigned OPCODE_W  = 5;
  localparam int unsigned ALU_OP_W  = 4;
  localparam int unsigned REG_SEL_W = 4;
  localparam int unsigned STATE_W   = 4;

  // IR field bit positions
  localparam int unsigned OPC_HI = 31;
  localparam int unsigned OPC_LO = 27;
  localparam int unsigned RA_HI  = 26;
  localparam int unsigned RA_LO  = 23;
  localparam int unsigned RB_HI  = 22;
  localparam int unsigned RB_LO  = 19;
  localparam int unsigned RC_HI  = 18;
  localparam int unsigned RC_LO  = 15;

  localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPCODE_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OPCODE_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OPCODE_W-1:0] OP_ROR  = 5'b00111;
  localparam logic [OPCODE_W-1:0] OP_ROL  = 5'b01000;
  localparam logic [OPCODE_W-1:0] OP_SHR  = 5'b01001;
  localparam logic [OPCODE_W-1:0] OP_SHRA = 5'b01010;
  localparam logic [OPCODE_W-1:0] OP_SHL  = 5'b01011;
  localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11011;

  localparam logic [ALU_OP_W-1:0] ALU_NONE = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'b0011;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'b0100;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'b0101;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_ROR  = 4'b0111;
  localparam logic [ALU_OP_W-1:0] ALU_ROL  = 4'b1000;
  localparam logic [ALU_OP_W-1:0] ALU_SHR  = 4'b1001;
  localparam logic [ALU_OP_W-1:0] ALU_SHRA = 4'b1010;
  localparam logic [ALU_OP_W-1:0] ALU_SHL  = 4'b1011;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_HALT = 4'd7
  } state_e;

  // Strobes that depend on the state alone and can be loaded alongside it
  typedef struct packed {
    logic run;
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic z_in;
    logic zlow_out;
    logic r_in;
  } strobe_t;

  function automatic strobe_t state_strobes(state_e s);
    strobe_t st;
    st     = '0;
    st.run = (s != S_IDLE) && (s != S_HALT);
    case (s)
      S_T0: begin
        st.pc_out = 1'b1;
        st.mar_in = 1'b1;
        st.inc_pc = 1'b1;
      end
      S_T1: begin
        st.read   = 1'b1;
        st.mdr_in = 1'b1;
      end
      S_T2: begin
        st.mdr_out = 1'b1;
        st.ir_in   = 1'b1;
      end
      S_T4: st.z_in = 1'b1;
      S_T5: begin
        st.zlow_out = 1'b1;
        st.r_in     = 1'b1;
      end
      default: ;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode classifier: ALU/NOP/HALT/illegal plus the ALU function select.
module instr_decoder
  import cpu_pkg::*;
#(
  parameter int unsigned OPC_W = OPCODE_W
) (
  input  logic [OPC_W-1:0]    opcode,
  output logic                is_alu,
  output logic                is_nop,
  output logic                is_halt,
  output logic                is_illegal,
  output logic [ALU_OP_W-1:0] alu_op
);

  always_comb begin
    is_alu  = 1'b0;
    is_nop  = 1'b0;
    is_halt = 1'b0;
    alu_op  = ALU_NONE;
    case (opcode)
      OP_ADD:  begin is_alu = 1'b1; alu_op = ALU_ADD;  end
      OP_SUB:  begin is_alu = 1'b1; alu_op = ALU_SUB;  end
      OP_AND:  begin is_alu = 1'b1; alu_op = ALU_AND;  end
      OP_OR:   begin is_alu = 1'b1; alu_op = ALU_OR;   end
      OP_ROR:  begin is_alu = 1'b1; alu_op = ALU_ROR;  end
      OP_ROL:  begin is_alu = 1'b1; alu_op = ALU_ROL;  end
      OP_SHR:  begin is_alu = 1'b1; alu_op = ALU_SHR;  end
      OP_SHRA: begin is_alu = 1'b1; alu_op = ALU_SHRA; end
      OP_SHL:  begin is_alu = 1'b1; alu_op = ALU_SHL;  end
      OP_NOP:  is_nop  = 1'b1;
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
    is_illegal = !(is_alu || is_nop || is_halt);
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer driving the single-bus datapath strobes.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned OPC_W = OPCODE_W
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start,
  input  logic                 mem_ready,
  input  logic [IR_W-1:0]      ir,
  output logic                 PCout,
  output logic                 MARin,
  output logic                 IncPC,
  output logic                 Read,
  output logic                 MDRin,
  output logic                 MDRout,
  output logic                 IRin,
  output logic                 Yin,
  output logic                 Zin,
  output logic                 Zlowout,
  output logic                 Rout,
  output logic [REG_SEL_W-1:0] Rout_sel,
  output logic                 Rin,
  output logic [REG_SEL_W-1:0] Rin_sel,
  output logic [ALU_OP_W-1:0]  alu_op,
  output logic                 run,
  output logic                 illegal,
  output logic [CNT_W-1:0]     instr_count
);

  state_e                state;
  strobe_t               stb;
  logic                  is_alu;
  logic                  is_nop;
  logic                  is_halt;
  logic                  is_illegal;
  logic [ALU_OP_W-1:0]   dec_alu_op;
  logic                  unused_ir_bits;

  assign unused_ir_bits = ^ir[RC_LO-1:0];

  instr_decoder #(.OPC_W(OPC_W)) u_decoder (
    .opcode     (ir[OPC_HI:OPC_LO]),
    .is_alu     (is_alu),
    .is_nop     (is_nop),
    .is_halt    (is_halt),
    .is_illegal (is_illegal),
    .alu_op     (dec_alu_op)
  );

  // State register; state-only strobes are loaded with the state they belong to
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state       <= S_IDLE;
      stb         <= '0;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state <= S_T0;
          stb   <= state_strobes(S_T0);
        end
        S_T0: begin
          state <= S_T1;
          stb   <= state_strobes(S_T1);
        end
        S_T1: if (mem_ready) begin
          state <= S_T2;
          stb   <= state_strobes(S_T2);
        end
        S_T2: begin
          state <= S_T3;
          stb   <= state_strobes(S_T3);
        end
        S_T3: begin
          if (is_alu) begin
            state <= S_T4;
            stb   <= state_strobes(S_T4);
          end else if (is_halt) begin
            state <= S_HALT;
            stb   <= state_strobes(S_HALT);
          end else if (is_nop) begin
            state <= S_T0;
            stb   <= state_strobes(S_T0);
          end else if (is_illegal) begin
            illegal <= 1'b1;
            state   <= S_T0;
            stb     <= state_strobes(S_T0);
          end
        end
        S_T4: begin
          state <= S_T5;
          stb   <= state_strobes(S_T5);
        end
        S_T5: begin
          instr_count <= instr_count + CNT_W'(1);
          if (start) begin
            state <= S_T0;
            stb   <= state_strobes(S_T0);
          end else begin
            state <= S_IDLE;
            stb   <= state_strobes(S_IDLE);
          end
        end
        S_HALT: ;
        default: begin
          state <= S_IDLE;
          stb   <= '0;
        end
      endcase
    end
  end

  // Register-file selects and ALU op follow the IR fields, which are only valid from T3 on
  always_comb begin
    Rout     = 1'b0;
    Yin      = 1'b0;
    Rout_sel = '0;
    Rin_sel  = '0;
    alu_op   = ALU_NONE;
    case (state)
      S_T3: if (is_alu) begin
        Rout     = 1'b1;
        Yin      = 1'b1;
        Rout_sel = ir[RB_HI:RB_LO];
      end
      S_T4: begin
        Rout     = 1'b1;
        Rout_sel = ir[RC_HI:RC_LO];
        alu_op   = dec_alu_op;
      end
      S_T5: Rin_sel = ir[RA_HI:RA_LO];
      default: ;
    endcase
  end

  assign run     = stb.run;
  assign PCout   = stb.pc_out;
  assign MARin   = stb.mar_in;
  assign IncPC   = stb.inc_pc;
  assign Read    = stb.read;
  assign MDRin   = stb.mdr_in;
  assign MDRout  = stb.mdr_out;
  assign IRin    = stb.ir_in;
  assign Zin     = stb.z_in;
  assign Zlowout = stb.zlow_out;
  assign Rin     = stb.r_in;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed vectors, hand-written corner sequences and a random
// instruction stream, all compared cycle by cycle against a trace model built from the opcode rules.
module tb_control_sequencer;

  // Narrow counter so the wraparound is reachable within a short run
  localparam int unsigned CW = 8;

  logic          clk;
  logic          clr;
  logic          start;
  logic          mem_ready;
  logic [31:0]   ir;
  logic          PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin, Zin, Zlowout;
  logic          Rout, Rin, run, illegal;
  logic [3:0]    Rout_sel, Rin_sel, alu_op;
  logic [CW-1:0] instr_count;

  control_sequencer #(.CNT_W(CW), .OPC_W(5)) dut (
    .clk(clk), .clr(clr), .start(start), .mem_ready(mem_ready), .ir(ir),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Read(Read), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
    .Rout(Rout), .Rout_sel(Rout_sel), .Rin(Rin), .Rin_sel(Rin_sel),
    .alu_op(alu_op), .run(run), .illegal(illegal), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_out, mar_in, inc_pc, read, mdr_in, mdr_out, ir_in, y_in, z_in, zlow_out;
    logic       r_out;
    logic [3:0] r_out_sel;
    logic       r_in;
    logic [3:0] r_in_sel;
    logic [3:0] alu_op;
    logic       run;
  } obs_t;

  typedef struct {
    logic [31:0] ir;
    int          waits;
    bit          go_idle;
    logic [3:0]  rb, rc, op, ra;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  int   count_m;
  bit   ill_m;
  bit   exp_alu, exp_halt;
  obs_t exp_q[$];
  obs_t got_q[$];
  vec_t vecs[4];

  localparam logic [31:0] ADD_R1 = 32'h18918000;  // add R1,R2,R3

  function automatic obs_t sample();
    obs_t o;
    o.pc_out = PCout;   o.mar_in = MARin;   o.inc_pc = IncPC;  o.read = Read;
    o.mdr_in = MDRin;   o.mdr_out = MDRout; o.ir_in = IRin;    o.y_in = Yin;
    o.z_in = Zin;       o.zlow_out = Zlowout;
    o.r_out = Rout;     o.r_out_sel = Rout_sel;
    o.r_in = Rin;       o.r_in_sel = Rin_sel;
    o.alu_op = alu_op;  o.run = run;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // At most one bus driver per cycle
  always @(negedge clk) begin
    if (!clr) begin
      total++;
      assert ($countones({PCout, MDRout, Zlowout, Rout}) <= 1)
        else begin
          bad++;
          $display("FAIL bus_drivers: got %b want at most one set", {PCout, MDRout, Zlowout, Rout});
        end
    end
  end

  // Expected per-cycle trace of one instruction from T0, plus flag/counter effects
  function automatic void build_model(input logic [31:0] iv, input int waits);
    obs_t       o;
    logic [4:0] opc;
    opc = iv[31:27];
    exp_q.delete();
    o = '0; o.run = 1'b1; o.pc_out = 1'b1; o.mar_in = 1'b1; o.inc_pc = 1'b1;
    exp_q.push_back(o);
    for (int k = 0; k <= waits; k++) begin
      o = '0; o.run = 1'b1; o.read = 1'b1; o.mdr_in = 1'b1;
      exp_q.push_back(o);
    end
    o = '0; o.run = 1'b1; o.mdr_out = 1'b1; o.ir_in = 1'b1;
    exp_q.push_back(o);
    exp_alu  = (opc >= 5'd3) && (opc <= 5'd11);
    exp_halt = (opc == 5'b11011);
    o = '0; o.run = 1'b1;
    if (exp_alu) begin
      o.r_out = 1'b1; o.y_in = 1'b1; o.r_out_sel = iv[22:19];
    end
    exp_q.push_back(o);
    if (exp_alu) begin
      o = '0; o.run = 1'b1; o.r_out = 1'b1; o.z_in = 1'b1;
      o.r_out_sel = iv[18:15]; o.alu_op = opc[3:0];
      exp_q.push_back(o);
      o = '0; o.run = 1'b1; o.zlow_out = 1'b1; o.r_in = 1'b1; o.r_in_sel = iv[26:23];
      exp_q.push_back(o);
      count_m = (count_m + 1) % (1 << CW);
    end else if (!exp_halt && opc != 5'b11010) begin
      ill_m = 1'b1;
    end
  endfunction

  // Runs one instruction starting at a negedge in T0; ends at the negedge after its last state
  task automatic exec(input logic [31:0] iv, input int waits, input bit go_idle);
    obs_t o;
    int   rc;
    build_model(iv, waits);
    got_q.delete();
    rc = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      o = sample();
      got_q.push_back(o);
      if (o.read) rc++;
      mem_ready = o.read ? (rc > waits) : 1'($urandom_range(0, 1));
      if (o.ir_in) ir = iv;
      if (o.zlow_out && go_idle) start = 1'b0;
      check($sformatf("trace[%0d] ir=%h", i, iv), 32'(o), 32'(exp_q[i]));
      step();
    end
    check("illegal_flag", 32'(illegal), 32'(ill_m));
    check("instr_count", 32'(instr_count), 32'(count_m));
    if (exp_halt) begin
      check("halted", 32'({run, PCout}), 32'h0);
    end else if (go_idle && exp_alu) begin
      check("idle_after_t5", 32'({run, PCout}), 32'h0);
      start = 1'b1;
      step();
      check("restart_t0", 32'({run, PCout, MARin}), 32'h7);
    end else begin
      check("next_t0", 32'({run, PCout, MARin}), 32'h7);
    end
  endtask

  function automatic logic [31:0] rand_ir();
    logic [4:0] opc;
    int         k;
    k = int'($urandom_range(0, 9));
    if (k < 7)       opc = 5'($urandom_range(3, 11));
    else if (k == 7) opc = 5'b11010;
    else begin
      opc = 5'($urandom_range(0, 31));
      if (opc == 5'b11011) opc = 5'b11111;
    end
    return {opc, 27'($urandom())};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   w;
    int   nrd;
    bit   found;
    obs_t o;

    vecs[0] = '{ir: 32'h43320000, waits: 0, go_idle: 1'b0, rb: 4'd6, rc: 4'd4, op: 4'b1000, ra: 4'd6};
    vecs[1] = '{ir: 32'h1A920000, waits: 3, go_idle: 1'b1, rb: 4'd2, rc: 4'd4, op: 4'b0011, ra: 4'd5};
    vecs[2] = '{ir: 32'h20918000, waits: 1, go_idle: 1'b0, rb: 4'd2, rc: 4'd3, op: 4'b0100, ra: 4'd1};
    vecs[3] = '{ir: {5'b01011, 4'd15, 4'd0, 4'd9, 15'h1234}, waits: 0, go_idle: 1'b0,
                rb: 4'd0, rc: 4'd9, op: 4'b1011, ra: 4'd15};

    clr = 1'b1; start = 1'b0; mem_ready = 1'b0; ir = '0;
    count_m = 0; ill_m = 1'b0;
    #12;
    check("reset_outputs", 32'(sample()), 32'h0);
    check("reset_count", 32'(instr_count), 32'h0);
    check("reset_illegal", 32'(illegal), 32'h0);
    @(negedge clk);
    clr = 1'b0;
    start = 1'b1;
    step();

    // Directed ALU vectors
    for (int v = 0; v < 4; v++) begin
      exec(vecs[v].ir, vecs[v].waits, vecs[v].go_idle);
      w = vecs[v].waits;
      nrd = 0;
      foreach (got_q[j]) if (got_q[j].read && got_q[j].mdr_in) nrd++;
      check($sformatf("vec%0d_t1_cycles", v), 32'(nrd), 32'(w + 1));
      check($sformatf("vec%0d_t3_rb", v), 32'(got_q[3+w].r_out_sel), 32'(vecs[v].rb));
      check($sformatf("vec%0d_t4_rc", v), 32'(got_q[4+w].r_out_sel), 32'(vecs[v].rc));
      check($sformatf("vec%0d_t4_op", v), 32'(got_q[4+w].alu_op), 32'(vecs[v].op));
      check($sformatf("vec%0d_t5_ra", v), 32'(got_q[5+w].r_in_sel), 32'(vecs[v].ra));
    end
    check("count_after_vectors", 32'(instr_count), 32'd4);

    // Undefined opcode, then NOP
    exec(32'hF8000000, 1, 1'b0);
    check("illegal_set", 32'(illegal), 32'h1);
    check("illegal_no_retire", 32'(instr_count), 32'd4);
    exec({5'b11010, 27'h5a5a5a5}, 2, 1'b0);

    // Random instruction stream
    for (int r = 0; r < 150; r++)
      exec(rand_ir(), int'($urandom_range(0, 4)), ($urandom_range(0, 7) == 0));

    // Counter wraparound
    for (int g = 0; g < 300 && count_m != 255; g++) exec(ADD_R1, 0, 1'b0);
    check("count_all_ones", 32'(instr_count), 32'hFF);
    exec(ADD_R1, 0, 1'b0);
    check("count_wrapped", 32'(instr_count), 32'h0);
    exec(ADD_R1, 0, 1'b0);

    // Asynchronous clear in the middle of T4
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      o = sample();
      mem_ready = 1'b1;
      if (o.ir_in) ir = ADD_R1;
      if (o.z_in) found = 1'b1;
      else step();
    end
    check("reached_t4", 32'(found), 32'h1);
    #2 clr = 1'b1;
    #1;
    check("clr_outputs", 32'(sample()), 32'h0);
    check("clr_count", 32'(instr_count), 32'h0);
    check("clr_illegal", 32'(illegal), 32'h0);
    count_m = 0; ill_m = 1'b0;
    start = 1'b0;
    #1 clr = 1'b0;
    @(negedge clk);
    check("idle_after_clr", 32'(sample()), 32'h0);
    start = 1'b1;
    step();
    check("start_from_idle", 32'({run, PCout, MARin, IncPC}), 32'hF);

    // HALT holds until clear regardless of start
    exec(32'hD8000000, 0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      start = k[0];
      mem_ready = 1'($urandom_range(0, 1));
      step();
      check($sformatf("halt_hold[%0d]", k), 32'(sample()), 32'h0);
    end
    #2 clr = 1'b1;
    #1;
    check("final_clr_count", 32'(instr_count), 32'h0);
    check("final_clr_run", 32'(run), 32'h0);
    clr = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit that drives the single-bus Datapath's strobe inputs (PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin, Zin, Zlowout, register in/out selects, ALU op).
- Sequences fetch (T0–T2) and three-operand register-format ALU execution (T3–T5), decoding the IR value that the Datapath returns.
- Replaces hand-written per-instruction testbench FSMs; sits directly upstream of Datapath.

Parameters:
- CNT_W, 16, width of retired-instruction counter
- OPC_W, 5, opcode field width (IR[31:27])

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  asynchronous active-high reset
- start  in  1  level; sequencer leaves IDLE when high
- mem_ready  in  1  memory read data valid (Mdatain stable)
- ir  in  32  Datapath IR register output
- PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin, Zin, Zlowout  out  1 each  Datapath strobes
- Rout  out  1  general-register bus drive enable
- Rout_sel  out  4  register index driving bus
- Rin  out  1  general-register load enable
- Rin_sel  out  4  register index loaded
- alu_op  out  4  ALU function select, valid while Zin=1
- run  out  1  high in any state except IDLE/HALT
- illegal  out  1  sticky, set on undefined opcode
- instr_count  out  CNT_W  retired ALU instructions

Behaviour:
- One clock (clk); clr asynchronous, active-high. On clr all outputs are 0 and state is IDLE, including mid-instruction and during a T1 wait. illegal and instr_count are cleared.
- Moore machine: every strobe and select is decoded from the state register only, plus ir fields in T3–T5. Each strobe is valid for the whole cycle of its state.
- States and transitions:
  - IDLE: all strobes 0. Go to T0 when start=1.
  - T0: PCout, MARin, IncPC. Go to T1.
  - T1: Read, MDRin. Stay while mem_ready=0; go to T2 on mem_ready=1. Read and MDRin stay high throughout the wait.
  - T2: MDRout, IRin. IR updates at the T2→T3 edge. Go to T3.
  - T3: decode ir[31:27].
    - Legal ALU opcode: Rout=1, Rout_sel=ir[22:19] (Rb), Yin. Go to T4.
    - HALT: go to HALT.
    - NOP: go to T0.
    - Other: set illegal, go to T0 with no register write.
  - T4: Rout=1, Rout_sel=ir[18:15] (Rc), Zin, alu_op=decoded op. Go to T5.
  - T5: Zlowout, Rin=1, Rin_sel=ir[26:23] (Ra). instr_count increments by 1. Go to T0 if start=1, else IDLE.
  - HALT: all strobes 0, run=0. Exit only via clr.
- Opcodes: add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011, nop 11010, halt 11011.
- alu_op is the opcode's low 4 bits for the ALU ops. alu_op is 0 outside T4.
- instr_count wraps from all-ones to 0 without a flag.
- Outside their states, Rout_sel and Rin_sel are 0.
- No two bus drivers are ever active in the same cycle; verification checks this as an assertion.
- Minimum instruction latency is 6 cycles, plus the number of cycles mem_ready is low in T1.

Decomposition:
- Package cpu_pkg holds:
  - opcode constants
  - alu_op constants
  - state enumeration (4-bit)
  - IR field bit positions
- One sub-module, instr_decoder: combinational; ir[31:27] → {is_alu, is_nop, is_halt, is_illegal, alu_op}.

Test Plan:
- clr pulse mid-T4, asynchronous to clk → all outputs 0 immediately; state IDLE; instr_count=0.
- start=1, mem_ready=1, ir=0x43320000 (rol R6,R6,R4) → six cycles T0..T5:
  - T3: Rout_sel=6, Yin
  - T4: Rout_sel=4, alu_op=1000, Zin
  - T5: Rin_sel=6, Zlowout
  - instr_count=1
- ir=0x1A920000 (add R5,R2,R4) with mem_ready low for 3 cycles in T1 → T1 lasts 4 cycles with Read=MDRin=1; T3 Rout_sel=2; T4 Rout_sel=4, alu_op=0011; T5 Rin_sel=5.
- ir=0xF8000000 (opcode 11111) → illegal=1 after T3; next state T0; Rin never asserted; instr_count unchanged.
- ir=0xD8000000 (halt) → HALT after T3; run=0; start toggling has no effect until clr.
- Preload instr_count to 0xFFFF via repeated adds → next T5 wraps it to 0x0000.
